// File: rtl/rps_pkg.sv
// rps_pkg: shared constants and helpers for the rock-paper-scissors judge.
//   Move encodings (one-hot), the 2-bit score codes, and a legality test.
package rps_pkg;

  localparam logic [2:0] ROCK     = 3'b100;
  localparam logic [2:0] PAPER    = 3'b010;
  localparam logic [2:0] SCISSORS = 3'b001;

  localparam logic [1:0] SC_DRAW    = 2'b00;
  localparam logic [1:0] SC_B_WIN   = 2'b01;
  localparam logic [1:0] SC_A_WIN   = 2'b10;
  localparam logic [1:0] SC_INVALID = 2'b11;

  // Only the three exact one-hot codes are legal; zero and multi-hot are not.
  function automatic logic is_legal(input logic [2:0] move);
    return (move == ROCK) || (move == PAPER) || (move == SCISSORS);
  endfunction

endpackage

// File: rtl/rps_judge.sv
// rps_judge: purely combinational round decision.
//   A, B  : player moves (one-hot)
//   score : SC_A_WIN / SC_B_WIN / SC_DRAW / SC_INVALID
module rps_judge
  import rps_pkg::*;
(
  input  logic [2:0] A,
  input  logic [2:0] B,
  output logic [1:0] score
);

  always_comb begin
    score = SC_INVALID;
    // Illegality is checked first so it dominates every other rule.
    if (!is_legal(A) || !is_legal(B)) begin
      score = SC_INVALID;
    end else if (A == B) begin
      score = SC_DRAW;
    end else if ((A == ROCK     && B == SCISSORS) ||
                 (A == SCISSORS && B == PAPER)    ||
                 (A == PAPER    && B == ROCK)) begin
      score = SC_A_WIN;
    end else begin
      score = SC_B_WIN;
    end
  end

endmodule

// File: rtl/rps_top_level.sv
// rps_top_level: registered rock-paper-scissors scoring unit.
//   clk, rst_n (sync, active-low), play strobe, moves A/B.
//   score/invalid : registered result of the last judged round
//   a_wins/b_wins/draws : saturating CNT_W-bit tallies
// All outputs come straight from registers; latency is one cycle.
module rps_top_level
  import rps_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             play,
  input  logic [2:0]       A,
  input  logic [2:0]       B,
  output logic [1:0]       score,
  output logic [CNT_W-1:0] a_wins,
  output logic [CNT_W-1:0] b_wins,
  output logic [CNT_W-1:0] draws,
  output logic             invalid
);

  logic [1:0] w_score;
  logic [2:0] w_inc;   // [0]=draw, [1]=B win, [2]=A win
  logic [1:0] r_score;
  logic       r_invalid;

  rps_judge u_judge (
    .A     (A),
    .B     (B),
    .score (w_score)
  );

  // Invalid rounds raise no increment, so they leave every tally alone.
  assign w_inc = {w_score == SC_A_WIN, w_score == SC_B_WIN, w_score == SC_DRAW}
               & {3{play}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_score   <= SC_DRAW;
      r_invalid <= 1'b0;
    end else if (play) begin
      r_score   <= w_score;
      r_invalid <= (w_score == SC_INVALID);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (w_inc[gi] && (r_cnt != {CNT_W{1'b1}})) begin
          // Hold at all-ones rather than wrapping.
          r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  endgenerate

  assign score   = r_score;
  assign invalid = r_invalid;
  assign draws   = g_cnt[0].r_cnt;
  assign b_wins  = g_cnt[1].r_cnt;
  assign a_wins  = g_cnt[2].r_cnt;

endmodule

// File: tb/tb_rps_top_level.sv
// Testbench for rps_top_level: two instances (CNT_W=8 and CNT_W=2) share the
// same stimulus; a rule-level model predicts every output each cycle, and
// literal expectations pin the model at key points.
module tb_rps_top_level;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       play = 1'b0;
  logic [2:0] A = 3'b000;
  logic [2:0] B = 3'b000;

  logic [1:0] score8, score2;
  logic       inv8, inv2;
  logic [7:0] aw8, bw8, dr8;
  logic [1:0] aw2, bw2, dr2;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  rps_top_level #(.CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .play(play), .A(A), .B(B),
    .score(score8), .a_wins(aw8), .b_wins(bw8), .draws(dr8), .invalid(inv8)
  );

  rps_top_level #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .play(play), .A(A), .B(B),
    .score(score2), .a_wins(aw2), .b_wins(bw2), .draws(dr2), .invalid(inv2)
  );

  // ---------------- behavioural model ----------------
  int m_score = 0;
  int m_aw = 0, m_bw = 0, m_dr = 0;   // unbounded counts

  function automatic int move_idx(input logic [2:0] m);
    // rock=0, paper=1, scissors=2; each beats the one two steps ahead mod 3
    return m[2] ? 0 : (m[1] ? 1 : 2);
  endfunction

  function automatic int rule(input logic [2:0] a, input logic [2:0] b);
    int d;
    if ($countones(a) != 1 || $countones(b) != 1) return 3;
    d = (move_idx(b) - move_idx(a) + 3) % 3;
    if (d == 0) return 0;
    if (d == 2) return 2;   // A beats B
    return 1;
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_score = 0; m_aw = 0; m_bw = 0; m_dr = 0;
    end else if (play) begin
      m_score = rule(A, B);
      if (m_score == 2) m_aw++;
      if (m_score == 1) m_bw++;
      if (m_score == 0) m_dr++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("score8",   int'(score8), m_score);
      check("invalid8", int'(inv8),   int'(m_score == 3));
      check("a_wins8",  int'(aw8),    sat(m_aw, 8));
      check("b_wins8",  int'(bw8),    sat(m_bw, 8));
      check("draws8",   int'(dr8),    sat(m_dr, 8));
      check("score2",   int'(score2), m_score);
      check("invalid2", int'(inv2),   int'(m_score == 3));
      check("a_wins2",  int'(aw2),    sat(m_aw, 2));
      check("b_wins2",  int'(bw2),    sat(m_bw, 2));
      check("draws2",   int'(dr2),    sat(m_dr, 2));
      $display("cyc t=%0t play=%0b A=%b B=%b score=%b inv=%0b aw=%0d bw=%0d dr=%0d aw2=%0d",
               $time, play, A, B, score8, inv8, aw8, bw8, dr8, aw2);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic p);
    @(negedge clk);
    A = a; B = b; play = p;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_score",   int'(score8), 0);
    check("rst_a_wins",  int'(aw8),    0);
    check("rst_invalid", int'(inv8),   0);
    rst_n = 1'b1;

    // Three A-win rounds back to back
    drive(3'b100, 3'b001, 1'b1);
    drive(3'b010, 3'b100, 1'b1);
    drive(3'b001, 3'b010, 1'b1);
    drive(3'b000, 3'b000, 1'b0);
    check("lit_awin_score", int'(score8), 2);
    check("lit_awin_aw",    int'(aw8),    3);
    check("lit_awin_bw",    int'(bw8),    0);
    check("lit_awin_dr",    int'(dr8),    0);

    // Three B-win rounds
    drive(3'b001, 3'b100, 1'b1);
    drive(3'b100, 3'b010, 1'b1);
    drive(3'b010, 3'b001, 1'b1);
    drive(3'b000, 3'b000, 1'b0);
    check("lit_bwin_score", int'(score8), 1);
    check("lit_bwin_bw",    int'(bw8),    3);

    // Draw
    drive(3'b010, 3'b010, 1'b1);
    drive(3'b000, 3'b000, 1'b0);
    check("lit_draw_score", int'(score8), 0);
    check("lit_draw_dr",    int'(dr8),    1);

    // Illegal moves: multi-hot A, then zero moves, then multi-hot B only
    drive(3'b011, 3'b100, 1'b1);
    drive(3'b000, 3'b000, 1'b0);
    check("lit_inv_score", int'(score8), 3);
    check("lit_inv_flag",  int'(inv8),   1);
    check("lit_inv_aw",    int'(aw8),    3);
    drive(3'b000, 3'b000, 1'b1);
    drive(3'b100, 3'b110, 1'b1);
    drive(3'b000, 3'b000, 1'b0);
    check("lit_inv2_score", int'(score8), 3);

    // Hold: inputs wander with play low
    drive(3'b100, 3'b001, 1'b0);
    drive(3'b010, 3'b010, 1'b0);
    drive(3'b001, 3'b100, 1'b0);
    drive(3'b111, 3'b000, 1'b0);
    drive(3'b010, 3'b001, 1'b0);
    check("lit_hold_score", int'(score8), 3);
    check("lit_hold_dr",    int'(dr8),    1);

    // Saturation on the CNT_W=2 instance from a fresh reset
    drive(3'b000, 3'b000, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(3'b100, 3'b001, 1'b1);
      drive(3'b000, 3'b000, 1'b0);
      check("lit_sat_aw2", int'(aw2), (k < 3) ? k + 1 : 3);
    end
    check("lit_sat_aw8", int'(aw8), 5);

    // Reset together with play: round discarded, everything zero
    drive(3'b010, 3'b100, 1'b1);
    rst_n = 1'b0;
    drive(3'b000, 3'b000, 1'b0);
    rst_n = 1'b1;
    check("lit_mrst_aw8",    int'(aw8),    0);
    check("lit_mrst_score",  int'(score8), 0);
    check("lit_mrst_aw2",    int'(aw2),    0);
    check("lit_mrst_inv",    int'(inv8),   0);

    drive(3'b000, 3'b000, 1'b0);
    @(posedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
